// File: rtl/ddr_avmm_responder.sv
// Avalon-MM responder standing in for the DDR EMIF user port: word writes, full-line
// reads, bursts, fixed read latency and optional periodic waitrequest injection.
module ddr_avmm_responder #(
  parameter int DATA_WIDTH       = 64,
  parameter int ADDR_WIDTH       = 26,
  parameter int BYTEEN_WIDTH     = 8,
  parameter int BURSTCOUNT_WIDTH = 7,
  parameter int MEM_LINES_LOG2   = 10,
  parameter int READ_LATENCY     = 4,
  parameter int STALL_PERIOD     = 5
) (
  input  logic                        DDR_USERCLK,
  input  logic                        SoftReset,
  input  logic                        DDR_read,
  input  logic                        DDR_write,
  input  logic [ADDR_WIDTH-1:0]       DDR_address,
  input  logic [DATA_WIDTH-1:0]       DDR_writedata,
  input  logic [BYTEEN_WIDTH-1:0]     DDR_byteenable,
  input  logic [BURSTCOUNT_WIDTH-1:0] DDR_burstcount,
  output logic                        DDR_waitrequest,
  output logic                        DDR_readdatavalid,
  output logic [8*DATA_WIDTH-1:0]     DDR_readdata,
  input  logic                        stall_en,
  output logic [31:0]                 rd_count,
  output logic [31:0]                 wr_count,
  output logic                        protocol_error
);

  localparam int LINE_WIDTH = 8 * DATA_WIDTH;
  localparam int WORD_AW    = MEM_LINES_LOG2 + 3;
  localparam int WORDS      = 2 ** WORD_AW;
  localparam int STALL_CW   = $clog2(STALL_PERIOD);

  localparam logic [BURSTCOUNT_WIDTH-1:0] BC_ONE     = BURSTCOUNT_WIDTH'(1);
  localparam logic [WORD_AW-1:0]          WORD_ONE   = WORD_AW'(1);
  localparam logic [MEM_LINES_LOG2-1:0]   LINE_ONE   = MEM_LINES_LOG2'(1);
  localparam logic [STALL_CW-1:0]         STALL_LAST = STALL_CW'(STALL_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_BURST
  } state_t;

  state_t                      cs;
  logic [BURSTCOUNT_WIDTH-1:0] wr_left;
  logic [BURSTCOUNT_WIDTH-1:0] rd_left;
  logic [WORD_AW-1:0]          wr_addr;
  logic [MEM_LINES_LOG2-1:0]   rd_line;
  logic [STALL_CW-1:0]         stall_cnt;

  logic [DATA_WIDTH-1:0]       mem [WORDS];
  logic [READ_LATENCY-1:0]     pipe_vld;
  logic [LINE_WIDTH-1:0]       pipe_data [READ_LATENCY];

  logic                        accept_wr;
  logic                        accept_rd;
  logic                        bc_zero;
  logic [BURSTCOUNT_WIDTH-1:0] bc_eff;
  logic                        commit_en;
  logic [WORD_AW-1:0]          commit_addr;
  logic                        issue_en;
  logic [MEM_LINES_LOG2-1:0]   issue_line;
  logic [LINE_WIDTH-1:0]       issue_data;
  logic                        proto_hit;

  // Address bits above the backing store alias onto it.
  logic unused_addr_bits;
  assign unused_addr_bits = ^DDR_address[ADDR_WIDTH-1:WORD_AW];

  assign DDR_waitrequest = SoftReset | (cs == RD_BURST) | (stall_en & (stall_cnt == '0));

  assign accept_wr = DDR_write & ~DDR_waitrequest;
  assign accept_rd = DDR_read & ~DDR_waitrequest;
  assign bc_zero   = (DDR_burstcount == '0);
  assign bc_eff    = bc_zero ? BC_ONE : DDR_burstcount;

  assign proto_hit = ((cs == IDLE) && (accept_wr || accept_rd) && (bc_zero || (DDR_read && DDR_write)))
                   || ((cs == WR_BURST) && DDR_read);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    commit_en   = 1'b0;
    commit_addr = '0;
    issue_en    = 1'b0;
    issue_line  = '0;
    case (cs)
      IDLE: begin
        commit_en   = accept_wr;
        commit_addr = DDR_address[WORD_AW-1:0];
        issue_en    = accept_rd & ~DDR_write;
        issue_line  = DDR_address[3 +: MEM_LINES_LOG2];
      end
      WR_BURST: begin
        commit_en   = accept_wr;
        commit_addr = wr_addr;
      end
      RD_BURST: begin
        issue_en   = 1'b1;
        issue_line = rd_line;
      end
      default: ;
    endcase
  end

  // The line is snapshotted at issue, so later writes never leak into an in-flight read.
  always_comb begin
    issue_data = '0;
    for (int k = 0; k < 8; k++) begin
      issue_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[{issue_line, 3'(k)}];
    end
  end

  // NOTE: the backing store and latency data pipe have no reset; contents must survive SoftReset.
  always_ff @(posedge DDR_USERCLK) begin
    if (commit_en) begin
      for (int b = 0; b < BYTEEN_WIDTH; b++) begin
        if (DDR_byteenable[b]) mem[commit_addr][b*8 +: 8] <= DDR_writedata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge DDR_USERCLK) begin
    pipe_data[0] <= issue_data;
    for (int i = 1; i < READ_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
  end

  // NOTE: all state here uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge DDR_USERCLK) begin
    if (SoftReset) begin
      cs                <= IDLE;
      wr_left           <= '0;
      rd_left           <= '0;
      wr_addr           <= '0;
      rd_line           <= '0;
      stall_cnt         <= '0;
      pipe_vld          <= '0;
      DDR_readdatavalid <= 1'b0;
      DDR_readdata      <= '0;
      rd_count          <= '0;
      wr_count          <= '0;
      protocol_error    <= 1'b0;
    end else begin
      stall_cnt <= (stall_cnt == STALL_LAST) ? '0 : stall_cnt + STALL_CW'(1);

      pipe_vld[0] <= issue_en;
      for (int i = 1; i < READ_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];

      DDR_readdatavalid <= pipe_vld[READ_LATENCY-1];
      if (pipe_vld[READ_LATENCY-1]) begin
        DDR_readdata <= pipe_data[READ_LATENCY-1];
        rd_count     <= rd_count + 32'd1;
      end

      if (commit_en) wr_count <= wr_count + 32'd1;
      if (proto_hit) protocol_error <= 1'b1;

      case (cs)
        IDLE: begin
          if (accept_wr) begin
            if (bc_eff != BC_ONE) begin
              wr_left <= bc_eff - BC_ONE;
              wr_addr <= commit_addr + WORD_ONE;
              cs      <= WR_BURST;
            end
          end else if (accept_rd) begin
            rd_left <= bc_eff - BC_ONE;
            rd_line <= issue_line + LINE_ONE;
            if (bc_eff != BC_ONE) cs <= RD_BURST;
          end
        end
        WR_BURST: begin
          if (accept_wr) begin
            wr_addr <= wr_addr + WORD_ONE;
            wr_left <= wr_left - BC_ONE;
            if (wr_left == BC_ONE) cs <= IDLE;
          end
        end
        RD_BURST: begin
          rd_line <= rd_line + LINE_ONE;
          rd_left <= rd_left - BC_ONE;
          if (rd_left == BC_ONE) cs <= IDLE;
        end
        default: cs <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_avmm_responder.sv
// Directed bench for ddr_avmm_responder: vector table for single-word writes plus
// hand-written burst, stall, reset and protocol-error sequences, checked against a word model.
module tb_ddr_avmm_responder;

  localparam int L     = 4;
  localparam int WORDS = 8192;

  logic         DDR_USERCLK = 1'b0;
  logic         SoftReset;
  logic         DDR_read;
  logic         DDR_write;
  logic [25:0]  DDR_address;
  logic [63:0]  DDR_writedata;
  logic [7:0]   DDR_byteenable;
  logic [6:0]   DDR_burstcount;
  logic         DDR_waitrequest;
  logic         DDR_readdatavalid;
  logic [511:0] DDR_readdata;
  logic         stall_en;
  logic [31:0]  rd_count;
  logic [31:0]  wr_count;
  logic         protocol_error;

  ddr_avmm_responder #(
    .DATA_WIDTH(64), .ADDR_WIDTH(26), .BYTEEN_WIDTH(8), .BURSTCOUNT_WIDTH(7),
    .MEM_LINES_LOG2(10), .READ_LATENCY(L), .STALL_PERIOD(5)
  ) dut (
    .DDR_USERCLK      (DDR_USERCLK),
    .SoftReset        (SoftReset),
    .DDR_read         (DDR_read),
    .DDR_write        (DDR_write),
    .DDR_address      (DDR_address),
    .DDR_writedata    (DDR_writedata),
    .DDR_byteenable   (DDR_byteenable),
    .DDR_burstcount   (DDR_burstcount),
    .DDR_waitrequest  (DDR_waitrequest),
    .DDR_readdatavalid(DDR_readdatavalid),
    .DDR_readdata     (DDR_readdata),
    .stall_en         (stall_en),
    .rd_count         (rd_count),
    .wr_count         (wr_count),
    .protocol_error   (protocol_error)
  );

  always #5 DDR_USERCLK = ~DDR_USERCLK;

  typedef struct {
    logic [511:0] data;
    int unsigned  cyc;
  } exp_t;

  typedef struct {
    logic [25:0] wr_addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [25:0] rd_addr;
    int          lane;
    logic [63:0] exp_word;
  } vec_t;

  int unsigned  cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  int           exp_rd = 0;
  int           exp_wr = 0;
  int           rx_count = 0;
  logic [63:0]  mmem [WORDS];
  logic [511:0] rx_lines [256];
  exp_t         exp_q [$];

  always @(posedge DDR_USERCLK) cyc <= cyc + 1;

  task automatic check(input string what, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", what, act, req);
    end
  endtask

  task automatic fail(input string what, input string msg);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s", what, msg);
  endtask

  // Every returned line is compared to the model snapshot taken at issue, and to its due cycle.
  always @(negedge DDR_USERCLK) begin : collect
    exp_t e;
    if (DDR_readdatavalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_valid", "got readdatavalid=1 required 0");
      end else begin
        e = exp_q.pop_front();
        check("rd_line", DDR_readdata, e.data);
        check("rd_latency", 512'(cyc), 512'(e.cyc));
      end
      rx_lines[rx_count % 256] = DDR_readdata;
      rx_count++;
    end
  end

  function automatic logic [511:0] model_line(input int unsigned line);
    logic [511:0] r;
    int unsigned base;
    base = (line % 1024) * 8;
    for (int k = 0; k < 8; k++) r[k*64 +: 64] = mmem[base + k];
    return r;
  endfunction

  task automatic model_write(input int unsigned addr, input logic [63:0] data, input logic [7:0] be);
    for (int b = 0; b < 8; b++) begin
      if (be[b]) mmem[addr % WORDS][b*8 +: 8] = data[b*8 +: 8];
    end
  endtask

  task automatic push_exp(input int unsigned line, input int unsigned due);
    exp_t e;
    e.data = model_line(line);
    e.cyc  = due;
    exp_q.push_back(e);
    exp_rd++;
  endtask

  // Returns 1ns after the edge that accepted the request held on the bus.
  task automatic wait_accept(input string what);
    for (int n = 0; n < 50; n++) begin
      @(negedge DDR_USERCLK);
      if (!DDR_waitrequest) begin
        @(posedge DDR_USERCLK);
        #1;
        return;
      end
      @(posedge DDR_USERCLK);
      #1;
    end
    fail(what, "waitrequest still 1 after 50 cycles, required 0");
  endtask

  task automatic wr_req(input logic [25:0] addr, input int n, input logic [63:0] base,
                        input logic [7:0] be, input bit with_rd);
    for (int i = 0; i < n; i++) begin
      DDR_write      = 1'b1;
      DDR_read       = with_rd;
      DDR_address    = addr;
      DDR_writedata  = base + 64'(i);
      DDR_byteenable = be;
      DDR_burstcount = 7'(n);
      wait_accept("wr_accept");
      model_write(int'(addr) + i, base + 64'(i), be);
      exp_wr++;
    end
    DDR_write = 1'b0;
    DDR_read  = 1'b0;
  endtask

  task automatic rd_req(input logic [25:0] addr, input int bc);
    int unsigned e;
    DDR_read       = 1'b1;
    DDR_address    = addr;
    DDR_burstcount = 7'(bc);
    wait_accept("rd_accept");
    e = cyc;
    for (int j = 0; j < ((bc == 0) ? 1 : bc); j++) push_exp(int'(addr >> 3) + j, e + j + L);
    DDR_read = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge DDR_USERCLK);
    if (exp_q.size() != 0) fail("drain", $sformatf("%0d reads outstanding, required 0", exp_q.size()));
    @(posedge DDR_USERCLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge DDR_USERCLK);
    #1;
  endtask

  // Reads due on or after the reset edge are dropped by the design, so the model drops them too.
  task automatic do_reset();
    exp_t keep [$];
    int unsigned r;
    SoftReset = 1'b1;
    @(negedge DDR_USERCLK);
    check("wait_in_reset", 512'(DDR_waitrequest), 512'(1));
    @(posedge DDR_USERCLK);
    #1;
    r = cyc;
    foreach (exp_q[i]) if (exp_q[i].cyc < r) keep.push_back(exp_q[i]);
    exp_q     = keep;
    exp_rd    = 0;
    exp_wr    = 0;
    SoftReset = 1'b0;
    @(negedge DDR_USERCLK);
    check("rst_valid",     512'(DDR_readdatavalid), 512'(0));
    check("rst_readdata",  DDR_readdata, 512'(0));
    check("rst_rd_count",  512'(rd_count), 512'(0));
    check("rst_wr_count",  512'(wr_count), 512'(0));
    check("rst_proto_err", 512'(protocol_error), 512'(0));
    check("rst_waitreq",   512'(DDR_waitrequest), 512'(0));
    @(posedge DDR_USERCLK);
    #1;
  endtask

  vec_t vt [8];

  initial begin
    int n0;
    int hi;
    int acc;
    logic w;

    vt[0] = '{26'h11,   64'h0000_0000_0000_A5A5, 8'hFF, 26'h10,   1, 64'h0000_0000_0000_A5A5};
    vt[1] = '{26'h12,   64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 26'h10,   2, 64'hFFFF_FFFF_FFFF_FFFF};
    vt[2] = '{26'h12,   64'h0123_4567_89AB_CDEF, 8'h0F, 26'h10,   2, 64'hFFFF_FFFF_89AB_CDEF};
    vt[3] = '{26'h12,   64'h0000_0000_0000_0000, 8'h80, 26'h10,   2, 64'h00FF_FFFF_89AB_CDEF};
    vt[4] = '{26'h12,   64'h1122_3344_5566_7788, 8'h00, 26'h10,   2, 64'h00FF_FFFF_89AB_CDEF};
    vt[5] = '{26'h1F,   64'hDEAD_BEEF_0000_0001, 8'hFF, 26'h18,   7, 64'hDEAD_BEEF_0000_0001};
    vt[6] = '{26'h2013, 64'h0000_0000_0000_CAFE, 8'hFF, 26'h2010, 3, 64'h0000_0000_0000_CAFE};
    vt[7] = '{26'h13,   64'h0000_0000_1234_5600, 8'h3C, 26'h10,   3, 64'h0000_0000_1234_CAFE};

    SoftReset      = 1'b1;
    DDR_read       = 1'b0;
    DDR_write      = 1'b0;
    DDR_address    = '0;
    DDR_writedata  = '0;
    DDR_byteenable = '0;
    DDR_burstcount = 7'd1;
    stall_en       = 1'b0;
    for (int i = 0; i < WORDS; i++) mmem[i] = '0;

    do_reset();

    // Prefill lines 0..7 so every later read has fully known contents.
    wr_req(26'h0, 64, 64'h0BAD_F00D_0000_0000, 8'hFF, 1'b0);
    idle(2);
    check("prefill_wr_count", 512'(wr_count), 512'(64));

    for (int i = 0; i < 8; i++) begin
      wr_req(vt[i].wr_addr, 1, vt[i].wdata, vt[i].be, 1'b0);
      rd_req(vt[i].rd_addr, 1);
      drain();
      check($sformatf("vec%0d_word", i), 512'(rx_lines[(rx_count - 1) % 256][vt[i].lane*64 +: 64]),
            512'(vt[i].exp_word));
    end

    // Four-beat write crossing from line 0 into line 1, then a two-line read.
    wr_req(26'h6, 4, 64'hB0, 8'hFF, 1'b0);
    n0 = rx_count;
    rd_req(26'h0, 2);
    drain();
    check("xline_l0_lane6", 512'(rx_lines[n0 % 256][6*64 +: 64]),       512'(64'hB0));
    check("xline_l0_lane7", 512'(rx_lines[n0 % 256][7*64 +: 64]),       512'(64'hB1));
    check("xline_l1_lane0", 512'(rx_lines[(n0 + 1) % 256][0 +: 64]),    512'(64'hB2));
    check("xline_l1_lane1", 512'(rx_lines[(n0 + 1) % 256][64 +: 64]),   512'(64'hB3));
    check("xline_rd_count", 512'(rd_count), 512'(10));
    check("xline_wr_count", 512'(wr_count), 512'(76));

    // Continuous single-line reads under stall injection: 1 stall in every 5 cycles.
    n0       = rx_count;
    hi       = 0;
    acc      = 0;
    stall_en = 1'b1;
    for (int c = 0; c < 25; c++) begin
      DDR_read       = 1'b1;
      DDR_address    = 26'((acc % 8) * 8);
      DDR_burstcount = 7'd1;
      @(negedge DDR_USERCLK);
      w = DDR_waitrequest;
      @(posedge DDR_USERCLK);
      #1;
      if (w) hi++;
      else begin
        push_exp(acc % 8, cyc + L);
        acc++;
      end
    end
    DDR_read = 1'b0;
    stall_en = 1'b0;
    drain();
    check("stall_high_cycles", 512'(hi), 512'(5));
    check("stall_accepted",    512'(acc), 512'(20));
    check("stall_returned",    512'(rx_count - n0), 512'(20));
    check("stall_rd_count",    512'(rd_count), 512'(exp_rd));

    // burstcount=0 read behaves as one line and latches protocol_error.
    check("pe_before_bc0", 512'(protocol_error), 512'(0));
    n0 = rx_count;
    rd_req(26'h18, 0);
    drain();
    idle(3);
    check("bc0_one_line", 512'(rx_count - n0), 512'(1));
    check("bc0_proto_err", 512'(protocol_error), 512'(1));
    idle(10);
    check("bc0_proto_sticky", 512'(protocol_error), 512'(1));

    // Reset while an 8-line read burst is in flight; only the first line is already due.
    n0 = rx_count;
    rd_req(26'h0, 8);
    idle(4);
    do_reset();
    idle(8);
    check("rst_burst_lines", 512'(rx_count - n0), 512'(1));
    rd_req(26'h0, 8);
    drain();
    check("reread_rd_count", 512'(rd_count), 512'(8));

    // Read and write together in IDLE: the write wins, no line returns.
    n0 = rx_count;
    wr_req(26'h20, 1, 64'h5EED, 8'hFF, 1'b1);
    idle(8);
    check("rw_no_line",   512'(rx_count - n0), 512'(0));
    check("rw_proto_err", 512'(protocol_error), 512'(1));
    check("rw_wr_count",  512'(wr_count), 512'(1));
    rd_req(26'h20, 1);
    drain();
    check("rw_write_won", 512'(rx_lines[(rx_count - 1) % 256][0 +: 64]), 512'(64'h5EED));

    idle(4);
    check("all_reads_returned", 512'(exp_q.size()), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
